// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer.
package conv_pkg;

  localparam int unsigned KSIZE = 3;
  localparam int unsigned ISIZE = 4;
  localparam int unsigned OSIZE = 2;
  localparam int unsigned NTAPS = 9;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ACC_W  = 20;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/conv_sequencer_if.sv
// Command, memory and result signals of the convolution sequencer.
// master: the sequencer; slave: the surrounding command/memory logic.
interface conv_sequencer_if
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W
) ();

  logic                            start;
  logic                            mem_done;
  logic [ISIZE*ISIZE*DATA_W-1:0]   a_flat;
  logic [NTAPS*DATA_W-1:0]         b_flat;
  logic                            mem_activate;
  logic                            busy;
  logic                            out_valid;
  logic [1:0]                      out_idx;
  logic [ACC_W-1:0]                out_data;
  logic                            done;
  logic                            err;

  modport master (
    input  start, mem_done, a_flat, b_flat,
    output mem_activate, busy, out_valid, out_idx, out_data, done, err
  );

  modport slave (
    output start, mem_done, a_flat, b_flat,
    input  mem_activate, busy, out_valid, out_idx, out_data, done, err
  );

endinterface

// File: rtl/conv_window_mux.sv
// Picks the image operand a[r+kr][c+kc] and kernel operand b[kr][kc]
// for the current output position and tap.
module conv_window_mux
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [ISIZE*ISIZE*DATA_W-1:0] a_flat,
  input  logic [NTAPS*DATA_W-1:0]       b_flat,
  input  logic [1:0]                    pos,
  input  logic [3:0]                    tap,
  output logic [DATA_W-1:0]             a_sel,
  output logic [DATA_W-1:0]             b_sel
);

  logic [DATA_W-1:0] a_arr [ISIZE*ISIZE];
  logic [DATA_W-1:0] b_arr [16];
  logic [1:0]        kr;
  logic [1:0]        kc;
  logic [1:0]        a_row;
  logic [1:0]        a_col;
  logic [3:0]        b_idx;

  for (genvar i = 0; i < ISIZE*ISIZE; i++) begin : g_a
    assign a_arr[i] = a_flat[i*DATA_W +: DATA_W];
  end

  for (genvar i = 0; i < 16; i++) begin : g_b
    if (i < NTAPS) begin : g_used
      assign b_arr[i] = b_flat[i*DATA_W +: DATA_W];
    end else begin : g_pad
      assign b_arr[i] = '0;
    end
  end

  // Tap number to kernel row/column.
  always_comb begin
    kr = 2'd0;
    kc = 2'd0;
    case (tap)
      4'd0: begin kr = 2'd0; kc = 2'd0; end
      4'd1: begin kr = 2'd0; kc = 2'd1; end
      4'd2: begin kr = 2'd0; kc = 2'd2; end
      4'd3: begin kr = 2'd1; kc = 2'd0; end
      4'd4: begin kr = 2'd1; kc = 2'd1; end
      4'd5: begin kr = 2'd1; kc = 2'd2; end
      4'd6: begin kr = 2'd2; kc = 2'd0; end
      4'd7: begin kr = 2'd2; kc = 2'd1; end
      4'd8: begin kr = 2'd2; kc = 2'd2; end
      default: begin kr = 2'd0; kc = 2'd0; end
    endcase
  end

  // Row-major element addresses into both matrices.
  always_comb begin
    a_row = {1'b0, pos[1]} + kr;
    a_col = {1'b0, pos[0]} + kc;
    b_idx = {2'b00, kr} * 4'(KSIZE) + {2'b00, kc};
    a_sel = a_arr[{a_row, a_col}];
    b_sel = b_arr[b_idx];
  end

endmodule

// File: rtl/conv_sequencer.sv
// 3x3 convolution sequencer over a 4x4 operand matrix: loads memory,
// then one MAC per cycle for each of the four output positions.
// Optional build macro CONV_SATURATE_EN clamps out_data to 2^DATA_W-1.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ACC_W        = DEF_ACC_W,
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  conv_sequencer_if.master bus
);

  localparam int unsigned TCNT_W = $clog2(LOAD_TIMEOUT + 1);

  state_t              state, state_next;
  logic [1:0]          pos, pos_next;
  logic [3:0]          tap, tap_next;
  logic [ACC_W-1:0]    acc, acc_next;
  logic [TCNT_W-1:0]   tcnt, tcnt_next;
  logic                mem_activate_q, mem_activate_next;
  logic                busy_q, busy_next;
  logic                out_valid_q, out_valid_next;
  logic [1:0]          out_idx_q, out_idx_next;
  logic [ACC_W-1:0]    out_data_q, out_data_next;
  logic                done_q, done_next;
  logic                err_q, err_next;

  logic [DATA_W-1:0]   a_sel;
  logic [DATA_W-1:0]   b_sel;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_sum;
  logic [ACC_W-1:0]    result;

  conv_window_mux #(.DATA_W(DATA_W)) u_window_mux (
    .a_flat (bus.a_flat),
    .b_flat (bus.b_flat),
    .pos    (pos),
    .tap    (tap),
    .a_sel  (a_sel),
    .b_sel  (b_sel)
  );

  // Running sum including the current tap.
  assign prod    = a_sel * b_sel;
  assign acc_sum = acc + ACC_W'(prod);

`ifdef CONV_SATURATE_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({DATA_W{1'b1}});
  assign result = (acc_sum > SAT_MAX) ? SAT_MAX : acc_sum;
`else
  assign result = acc_sum;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_next        = state;
    pos_next          = pos;
    tap_next          = tap;
    acc_next          = acc;
    tcnt_next         = tcnt;
    mem_activate_next = 1'b0;
    out_valid_next    = 1'b0;
    out_idx_next      = out_idx_q;
    out_data_next     = out_data_q;
    done_next         = 1'b0;
    err_next          = err_q;
    case (state)
      IDLE: begin
        tcnt_next = '0;
        if (bus.start) begin
          state_next        = LOAD;
          err_next          = 1'b0;
          mem_activate_next = 1'b1;
        end
      end
      LOAD: begin
        if (bus.mem_done) begin
          state_next = MAC;
          pos_next   = 2'd0;
          tap_next   = 4'd0;
          acc_next   = '0;
        end else if (tcnt == TCNT_W'(LOAD_TIMEOUT - 1)) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else begin
          tcnt_next         = tcnt + TCNT_W'(1);
          mem_activate_next = 1'b1;
        end
      end
      MAC: begin
        acc_next = acc_sum;
        if (tap == 4'(NTAPS - 1)) begin
          state_next     = EMIT;
          out_valid_next = 1'b1;
          out_idx_next   = pos;
          out_data_next  = result;
        end else begin
          tap_next = tap + 4'd1;
        end
      end
      EMIT: begin
        if (pos != 2'(OSIZE*OSIZE - 1)) begin
          state_next = MAC;
          pos_next   = pos + 2'd1;
          tap_next   = 4'd0;
          acc_next   = '0;
        end else begin
          state_next = DONE;
          done_next  = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pos            <= '0;
      tap            <= '0;
      acc            <= '0;
      tcnt           <= '0;
      mem_activate_q <= 1'b0;
      busy_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      out_idx_q      <= '0;
      out_data_q     <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state          <= state_next;
      pos            <= pos_next;
      tap            <= tap_next;
      acc            <= acc_next;
      tcnt           <= tcnt_next;
      mem_activate_q <= mem_activate_next;
      busy_q         <= busy_next;
      out_valid_q    <= out_valid_next;
      out_idx_q      <= out_idx_next;
      out_data_q     <= out_data_next;
      done_q         <= done_next;
      err_q          <= err_next;
    end
  end

  assign bus.mem_activate = mem_activate_q;
  assign bus.busy         = busy_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_idx      = out_idx_q;
  assign bus.out_data     = out_data_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;

endmodule
